cbu_interval_ctrl: RTL and testbench

Sequencer for a cascaded 2-bit up-counter chain that measures event intervals. On a START request it latches a terminal count, clears the chain, and gates the chain's carry-in (CAI) with an event strobe. It stops when the chain value equals the terminal count, then holds DONE until acknowledged. It sits between a host or control FSM and the macro counter library, and is the standard way to run a counter chain as a bounded event counter.

---
 rtl/cbu_ctrl_pkg.sv | 15 +
 rtl/cbu_chain.sv | 35 +++
 rtl/cbu_interval_ctrl.sv | 79 +++++++
 tb/tb_cbu_interval_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbu_ctrl_pkg.sv
// Shared types for the interval controller: FSM state encoding and chain width helper.
package cbu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } cbu_state_e;

  function automatic int cbu_width(input int nslice);
    return 2 * nslice;
  endfunction

endpackage

// File: rtl/cbu_chain.sv
// Cascaded 2-bit up-counter slices; each slice advances when the carry rippling in from below is set.
module cbu_chain
  import cbu_ctrl_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                         CLK,
  input  logic                         clr,
  input  logic                         cai,
  output logic [cbu_width(NSLICE)-1:0] count
);

  logic [NSLICE-1:0] carry;

  assign carry[0] = cai;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    logic [1:0] q;

    always_ff @(posedge CLK) begin
      if (clr)
        q <= 2'd0;
      else if (carry[i])
        q <= q + 2'd1;
    end

    // The top slice's carry-out is never used outside the chain.
    if (i < NSLICE - 1) begin : g_cao
      assign carry[i+1] = carry[i] & (&q);
    end

    assign count[2*i +: 2] = q;
  end

endmodule

// File: rtl/cbu_interval_ctrl.sv
// Sequencer running a cbu_chain as a bounded event counter: latch terminal count, clear, count events, hold DONE.
module cbu_interval_ctrl
  import cbu_ctrl_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                         CLK,
  input  logic                         CD,
  input  logic                         START,
  input  logic [cbu_width(NSLICE)-1:0] TERM,
  input  logic                         EVT,
  input  logic                         ABORT,
  input  logic                         ACK,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [cbu_width(NSLICE)-1:0] COUNT
);

  localparam int W = cbu_width(NSLICE);

  cbu_state_e     state_q, state_d;
  logic [W-1:0]   term_q;
  logic           fsm_clr;
  logic           fsm_cai;
  logic           at_term;
  logic           accept_start;

  assign at_term      = (COUNT == term_q);
  assign accept_start = (state_q == ST_IDLE) && START && !ABORT;

  always_ff @(posedge CLK) begin
    if (CD) begin
      state_q <= ST_IDLE;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start)
        term_q <= TERM;
    end
  end

  always_comb begin
    state_d = state_q;
    fsm_clr = 1'b0;
    fsm_cai = 1'b0;
    case (state_q)
      ST_IDLE:  if (START) state_d = ST_CLEAR;
      ST_CLEAR: begin
        fsm_clr = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (at_term) state_d = ST_DONE;
        else         fsm_cai = EVT;
      end
      ST_DONE:  if (ACK) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort wins over every transition and freezes the chain where it stands.
    if (ABORT) begin
      state_d = ST_IDLE;
      fsm_clr = 1'b0;
      fsm_cai = 1'b0;
    end
  end

  cbu_chain #(
    .NSLICE(NSLICE)
  ) u_chain (
    .CLK   (CLK),
    .clr   (CD | fsm_clr),
    .cai   (fsm_cai),
    .count (COUNT)
  );

  assign BUSY = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_cbu_interval_ctrl.sv
// Self-checking bench for cbu_interval_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_cbu_interval_ctrl;

  localparam int NSLICE = 4;
  localparam int W      = 2 * NSLICE;

  logic         CLK = 1'b0;
  logic         CD, START, EVT, ABORT, ACK;
  logic [W-1:0] TERM;
  logic         BUSY, DONE;
  logic [W-1:0] COUNT;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: phase 0 idle, 1 clearing, 2 counting, 3 finished.
  int m_ph   = 0;
  int m_cnt  = 0;
  int m_term = 0;

  always #5 CLK = ~CLK;

  cbu_interval_ctrl #(.NSLICE(NSLICE)) dut (
    .CLK   (CLK),
    .CD    (CD),
    .START (START),
    .TERM  (TERM),
    .EVT   (EVT),
    .ABORT (ABORT),
    .ACK   (ACK),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .COUNT (COUNT)
  );

  function automatic logic [W+1:0] exp_vec();
    logic b, d;
    b = (m_ph == 1) || (m_ph == 2);
    d = (m_ph == 3);
    return {b, d, W'(m_cnt)};
  endfunction

  // Advance one clock; the model consumes the inputs that were stable before the edge.
  task automatic tick();
    logic cd, st, ev, ab, ak;
    int   tm;
    cd = CD; st = START; ev = EVT; ab = ABORT; ak = ACK; tm = int'(TERM);
    @(posedge CLK);
    if (cd) begin
      m_ph = 0; m_cnt = 0; m_term = 0;
    end else if (ab) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (st) begin m_term = tm; m_ph = 1; end
        1: begin m_cnt = 0; m_ph = 2; end
        2: if (m_cnt == m_term) m_ph = 3;
           else if (ev) m_cnt = (m_cnt + 1) % (1 << W);
        default: if (ak) m_ph = 0;
      endcase
    end
    #1;
  endtask

  task automatic idle_inputs();
    CD = 1'b0; START = 1'b0; EVT = 1'b0; ABORT = 1'b0; ACK = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    TERM = 8'h3C;
    CD = 1'b1;
    tick();
    tick();
    CD = 1'b0;
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b count=%h, want 0 0 00", BUSY, DONE, COUNT);
    end
  endtask

  task automatic test_basic();
    int busy_cycles = 0;
    int done_at = -1;
    TERM = 8'd5; EVT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      n_chk++;
      if ({BUSY, DONE, COUNT} !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_cyc%0d: got %b, want %b", k, {BUSY, DONE, COUNT}, exp_vec());
      end
      if (BUSY) busy_cycles++;
      if (DONE && done_at < 0) done_at = k;
      if (k < 12) tick();
    end
    n_chk++;
    if (busy_cycles != 7) begin
      n_fail++;
      $display("FAIL basic_busy_len: got %0d, want 7", busy_cycles);
    end
    n_chk++;
    if (done_at != 8) begin
      n_fail++;
      $display("FAIL basic_done_latency: got %0d, want 8", done_at);
    end
    n_chk++;
    if (COUNT !== 8'd5) begin
      n_fail++;
      $display("FAIL basic_final_count: got %h, want 05", COUNT);
    end
    EVT = 1'b0; ACK = 1'b1;
    tick();
    ACK = 1'b0;
    n_chk++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack: got done=%b busy=%b, want 0 0", DONE, BUSY);
    end
  endtask

  task automatic test_sparse();
    logic seen_done = 1'b0;
    TERM = 8'd3; EVT = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      EVT = k[0];
      tick();
      n_chk++;
      if ({BUSY, DONE, COUNT} !== exp_vec() || COUNT > 8'd3) begin
        n_fail++;
        $display("FAIL sparse_cyc%0d: got %b, want %b (count<=3)", k, {BUSY, DONE, COUNT}, exp_vec());
      end
      if (DONE) seen_done = 1'b1;
    end
    n_chk++;
    if (!seen_done || COUNT !== 8'd3) begin
      n_fail++;
      $display("FAIL sparse_end: got done_seen=%b count=%h, want 1 03", seen_done, COUNT);
    end
    EVT = 1'b0; ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int want_lat, input logic [W-1:0] want_cnt);
    int done_at = -1;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      n_chk++;
      if ({BUSY, DONE, COUNT} !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s_cyc%0d: got %b, want %b", name, k, {BUSY, DONE, COUNT}, exp_vec());
      end
      if (DONE) done_at = k;
      else tick();
    end
    n_chk++;
    if (done_at != want_lat || COUNT !== want_cnt) begin
      n_fail++;
      $display("FAIL %s_done: got latency=%0d count=%h, want %0d %h", name, done_at, COUNT, want_lat, want_cnt);
    end
    EVT = 1'b0; ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  task automatic test_boundaries();
    TERM = 8'd0; EVT = 1'b1;
    run_to_done("term0", 3, 8'h00);
    TERM = 8'hFF; EVT = 1'b1;
    run_to_done("termff", 258, 8'hFF);
  endtask

  task automatic wait_count(input string name, input logic [W-1:0] val);
    int k = 0;
    while (COUNT !== val && k < 50) begin
      tick();
      k++;
    end
    if (COUNT !== val) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got count=%h, want %h", name, COUNT, val);
    end
  endtask

  task automatic test_abort();
    TERM = 8'd9; EVT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    wait_count("abort_reach2", 8'd2);
    ABORT = 1'b1; START = 1'b1;
    tick();
    ABORT = 1'b0; START = 1'b0;
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b0, 8'd2} || {BUSY, DONE, COUNT} !== exp_vec()) begin
      n_fail++;
      $display("FAIL abort_hold: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b0, 8'd2});
    end
    tick();
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL abort_idle: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b0, 8'd2});
    end
    TERM = 8'd4;
    run_to_done("abort_restart", 7, 8'd4);
  endtask

  task automatic test_mid_reset();
    TERM = 8'd20; EVT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    wait_count("midrst_reach7", 8'd7);
    CD = 1'b1;
    tick();
    CD = 1'b0; EVT = 1'b0;
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b0, 8'd0} || {BUSY, DONE, COUNT} !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_ignored();
    TERM = 8'd6; EVT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    // START with a new TERM and ACK while counting must not disturb the run.
    START = 1'b1; TERM = 8'd2; ACK = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    ACK = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b1, 8'd6} || {BUSY, DONE, COUNT} !== exp_vec()) begin
      n_fail++;
      $display("FAIL ignored_run: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b1, 8'd6});
    end
    TERM = 8'd1;
    tick();
    tick();
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b1, 8'd6}) begin
      n_fail++;
      $display("FAIL ignored_done: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b1, 8'd6});
    end
    START = 1'b0; EVT = 1'b0; ACK = 1'b1;
    tick();
    tick();
    ACK = 1'b0;
    n_chk++;
    if ({BUSY, DONE, COUNT} !== {1'b0, 1'b0, 8'd6} || {BUSY, DONE, COUNT} !== exp_vec()) begin
      n_fail++;
      $display("FAIL ignored_ack_idle: got %b, want %b", {BUSY, DONE, COUNT}, {1'b0, 1'b0, 8'd6});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      CD    = ($urandom_range(0, 249) == 0);
      START = ($urandom_range(0, 5) == 0);
      TERM  = W'($urandom_range(0, 12));
      EVT   = $urandom_range(0, 1);
      ABORT = !START && ($urandom_range(0, 39) == 0);
      ACK   = ($urandom_range(0, 3) == 0);
      tick();
      n_chk++;
      if ({BUSY, DONE, COUNT} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %b, want %b", k, {BUSY, DONE, COUNT}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_boundaries();
    test_abort();
    test_mid_reset();
    test_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
